// File: rtl/cc_multispeedcomparator_pkg.sv
// ---------------------------------------------------------------------------
// cc_multispeedcomparator_pkg
//
// Shared definitions for the multi-channel speed comparator.
//
// Contents:
//   ST_BELOW / ST_ARMING / ST_ABOVE / ST_RELEASING
//       Per-channel alarm FSM state encodings.
//   clog2(value)
//       Ceiling log2, usable in constant expressions.
//   chsel_width(channels)
//       Width of the limit-select bus; it is never narrower than one bit.
//   count_width(persist)
//       Width of the persistence counter. The counter has to hold PERSIST
//       itself without wrapping.
// ---------------------------------------------------------------------------
package cc_multispeedcomparator_pkg;

    // Alarm FSM states. ABOVE and RELEASING both drive the alarm.
    localparam logic [1:0] ST_BELOW     = 2'd0;
    localparam logic [1:0] ST_ARMING    = 2'd1;
    localparam logic [1:0] ST_ABOVE     = 2'd2;
    localparam logic [1:0] ST_RELEASING = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single channel still needs a one-bit select port.
    function automatic int chsel_width(input int channels);
        return (channels <= 1) ? 1 : clog2(channels);
    endfunction

    function automatic int count_width(input int persist);
        return (persist < 1) ? 1 : clog2(persist + 1);
    endfunction

endpackage

// File: rtl/cc_speedchannel.sv
// ---------------------------------------------------------------------------
// cc_speedchannel
//
// Single channel of the multi-speed comparator. It holds:
//   - the channel's limit register,
//   - the hi / release comparisons,
//   - the persistence FSM with its counter,
//   - the sticky alarm flag.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   sample       in   [DATAWIDTH] speed sample for this channel
//   sample_valid in   sample is present on this edge
//   load         in   active-high limit write, already decoded for this channel
//   load_value   in   [DATAWIDTH] new limit value
//   clear        in   clears the sticky flag
//   alarm_n      out  registered alarm, low in ABOVE and RELEASING
//   sticky       out  set when the alarm is entered; held until cleared
// ---------------------------------------------------------------------------
module cc_speedchannel
    import cc_multispeedcomparator_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   PERSIST    = 3,
    parameter int                   HYST       = 4,
    parameter logic [DATAWIDTH-1:0] LIMIT_INIT = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] sample,
    input  logic                 sample_valid,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] load_value,
    input  logic                 clear,
    output logic                 alarm_n,
    output logic                 sticky
);

    localparam int                   CNTW        = count_width(PERSIST);
    localparam logic [CNTW-1:0]      PERSIST_CNT = CNTW'(PERSIST);
    localparam logic [DATAWIDTH:0]   HYST_EXT    = (DATAWIDTH + 1)'(HYST);

    logic [DATAWIDTH-1:0] limit;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNTW-1:0]      cnt;
    logic [CNTW-1:0]      cnt_nxt;
    logic [CNTW-1:0]      cnt_inc;
    logic                 hi;
    logic                 rel;
    logic                 enter_above;
    logic                 alarm_nxt;

    // The release test uses one extra bit so that sample + HYST cannot
    // overflow. When the limit is at or below HYST, the release test can
    // never be true. A channel in that state leaves the alarm only
    // through a reload or a reset.
    assign hi      = (sample >= limit);
    assign rel     = ({1'b0, limit} > HYST_EXT) &&
                     (({1'b0, sample} + HYST_EXT) < {1'b0, limit});
    assign cnt_inc = cnt + CNTW'(1);

    // Next-state logic for one valid sample. The counter runs toward
    // PERSIST in both directions: it counts consecutive hi samples while
    // arming and consecutive rel samples while releasing.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        enter_above = 1'b0;
        case (state)
            ST_BELOW: begin
                if (hi) begin
                    if (PERSIST == 1) begin
                        state_nxt   = ST_ABOVE;
                        cnt_nxt     = '0;
                        enter_above = 1'b1;
                    end else begin
                        state_nxt = ST_ARMING;
                        cnt_nxt   = CNTW'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (hi) begin
                    if (cnt_inc == PERSIST_CNT) begin
                        state_nxt   = ST_ABOVE;
                        cnt_nxt     = '0;
                        enter_above = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = ST_BELOW;
                    cnt_nxt   = '0;
                end
            end
            ST_ABOVE: begin
                if (rel) begin
                    if (PERSIST == 1) begin
                        state_nxt = ST_BELOW;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_RELEASING;
                        cnt_nxt   = CNTW'(1);
                    end
                end
            end
            ST_RELEASING: begin
                if (rel) begin
                    if (cnt_inc == PERSIST_CNT) begin
                        state_nxt = ST_BELOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = ST_ABOVE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_BELOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign alarm_nxt = !((state_nxt == ST_ABOVE) || (state_nxt == ST_RELEASING));

    // Limit register, FSM and alarm flop. A limit write takes priority
    // over a sample on the same edge. The write restarts the channel from
    // BELOW, so a new limit never inherits a half-counted persistence run.
    // The alarm is kept in its own flop. This lets the output come
    // straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit   <= LIMIT_INIT;
            state   <= ST_BELOW;
            cnt     <= '0;
            alarm_n <= 1'b1;
        end else if (load) begin
            limit   <= load_value;
            state   <= ST_BELOW;
            cnt     <= '0;
            alarm_n <= 1'b1;
        end else if (sample_valid) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            alarm_n <= alarm_nxt;
        end
    end

    // Sticky flag. If an alarm entry and a clear land on the same edge,
    // the entry wins, so that edge's event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else begin
            sticky <= (enter_above && sample_valid && !load) || (sticky && !clear);
        end
    end

endmodule

// File: rtl/cc_multispeedcomparator.sv
// ---------------------------------------------------------------------------
// cc_multispeedcomparator
//
// Multi-channel speed comparator. Each channel compares its sample against
// a programmable limit. Each channel raises an active-low alarm after
// PERSIST consecutive samples at or above the limit. The alarm is released
// after PERSIST consecutive samples more than HYST below the limit.
//
// Ports:
//   CC_MULTISPEEDCOMPARATOR_CLOCK_50          in   clock, rising edge
//   CC_MULTISPEEDCOMPARATOR_RESET_InLow       in   asynchronous active-low reset
//   CC_MULTISPEEDCOMPARATOR_data_InBUS        in   [CHANNELS*DATAWIDTH] samples,
//                                                  channel i at [i*DATAWIDTH +: DATAWIDTH]
//   CC_MULTISPEEDCOMPARATOR_dataValid_InHigh  in   all channels sampled this edge
//   CC_MULTISPEEDCOMPARATOR_limit_InBUS       in   [DATAWIDTH] limit write data
//   CC_MULTISPEEDCOMPARATOR_limitSel_InBUS    in   [CHSELW] target channel of the write
//   CC_MULTISPEEDCOMPARATOR_loadSignal_InLow  in   synchronous limit write, active-low
//   CC_MULTISPEEDCOMPARATOR_clear_InHigh      in   clears all sticky flags
//   CC_MULTISPEEDCOMPARATOR_signal_OutLow     out  [CHANNELS] per-channel alarm, active-low
//   CC_MULTISPEEDCOMPARATOR_any_OutLow        out  low when any channel is in alarm
//   CC_MULTISPEEDCOMPARATOR_sticky_OutHigh    out  [CHANNELS] latched alarm-entry flags
// ---------------------------------------------------------------------------
module cc_multispeedcomparator
    import cc_multispeedcomparator_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   CHANNELS   = 4,
    parameter int                   PERSIST    = 3,
    parameter int                   HYST       = 4,
    parameter logic [DATAWIDTH-1:0] LIMIT_INIT = '1,
    localparam int                  CHSELW     = chsel_width(CHANNELS)
) (
    input  logic                          CC_MULTISPEEDCOMPARATOR_CLOCK_50,
    input  logic                          CC_MULTISPEEDCOMPARATOR_RESET_InLow,
    input  logic [CHANNELS*DATAWIDTH-1:0] CC_MULTISPEEDCOMPARATOR_data_InBUS,
    input  logic                          CC_MULTISPEEDCOMPARATOR_dataValid_InHigh,
    input  logic [DATAWIDTH-1:0]          CC_MULTISPEEDCOMPARATOR_limit_InBUS,
    input  logic [CHSELW-1:0]             CC_MULTISPEEDCOMPARATOR_limitSel_InBUS,
    input  logic                          CC_MULTISPEEDCOMPARATOR_loadSignal_InLow,
    input  logic                          CC_MULTISPEEDCOMPARATOR_clear_InHigh,
    output logic [CHANNELS-1:0]           CC_MULTISPEEDCOMPARATOR_signal_OutLow,
    output logic                          CC_MULTISPEEDCOMPARATOR_any_OutLow,
    output logic [CHANNELS-1:0]           CC_MULTISPEEDCOMPARATOR_sticky_OutHigh
);

    logic [CHANNELS-1:0] load_ch;

    // One channel per generate iteration. The write strobe is decoded per
    // channel. A select value at or above CHANNELS matches no iteration,
    // so such a write is dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        assign load_ch[i] = !CC_MULTISPEEDCOMPARATOR_loadSignal_InLow &&
                            (CC_MULTISPEEDCOMPARATOR_limitSel_InBUS == CHSELW'(i));

        cc_speedchannel #(
            .DATAWIDTH  (DATAWIDTH),
            .PERSIST    (PERSIST),
            .HYST       (HYST),
            .LIMIT_INIT (LIMIT_INIT)
        ) u_channel (
            .clk          (CC_MULTISPEEDCOMPARATOR_CLOCK_50),
            .rst_n        (CC_MULTISPEEDCOMPARATOR_RESET_InLow),
            .sample       (CC_MULTISPEEDCOMPARATOR_data_InBUS[i*DATAWIDTH +: DATAWIDTH]),
            .sample_valid (CC_MULTISPEEDCOMPARATOR_dataValid_InHigh),
            .load         (load_ch[i]),
            .load_value   (CC_MULTISPEEDCOMPARATOR_limit_InBUS),
            .clear        (CC_MULTISPEEDCOMPARATOR_clear_InHigh),
            .alarm_n      (CC_MULTISPEEDCOMPARATOR_signal_OutLow[i]),
            .sticky       (CC_MULTISPEEDCOMPARATOR_sticky_OutHigh[i])
        );
    end

    // The aggregate alarm is derived combinationally from the registered
    // per-channel alarms. It therefore adds no extra cycle of latency.
    assign CC_MULTISPEEDCOMPARATOR_any_OutLow = &CC_MULTISPEEDCOMPARATOR_signal_OutLow;

endmodule

// File: tb/tb_cc_multispeedcomparator.sv
// ---------------------------------------------------------------------------
// tb_cc_multispeedcomparator
//
// Self-checking bench for cc_multispeedcomparator. The main instance uses
// four channels, PERSIST=3 and HYST=4. A second instance has three
// channels; it shows that an out-of-range select writes no limit.
// Expected values come from a per-channel model. The model tracks:
//   - whether the channel is alarmed,
//   - the length of the current qualifying run,
//   - the limit,
//   - the sticky flag.
// ---------------------------------------------------------------------------
module tb_cc_multispeedcomparator;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int PERS = 3;
    localparam int HY   = 4;

    logic            clk;
    logic            rst_n;
    logic [NCH*DW-1:0] data_bus;
    logic            valid;
    logic [DW-1:0]   limit_bus;
    logic [1:0]      sel;
    logic            load_n;
    logic            clear;
    logic [NCH-1:0]  sig;
    logic            any_n;
    logic [NCH-1:0]  sticky;

    logic [1:0]      sel3;
    logic            load3_n;
    logic [2:0]      sig3;
    logic            any3;
    logic [2:0]      sticky3;

    int  m_limit  [NCH];
    bit  m_alarm  [NCH];
    int  m_run    [NCH];
    bit  m_sticky [NCH];

    int tests_run;
    int tests_failed;

    cc_multispeedcomparator #(
        .DATAWIDTH (DW), .CHANNELS (NCH), .PERSIST (PERS), .HYST (HY)
    ) dut (
        .CC_MULTISPEEDCOMPARATOR_CLOCK_50         (clk),
        .CC_MULTISPEEDCOMPARATOR_RESET_InLow      (rst_n),
        .CC_MULTISPEEDCOMPARATOR_data_InBUS       (data_bus),
        .CC_MULTISPEEDCOMPARATOR_dataValid_InHigh (valid),
        .CC_MULTISPEEDCOMPARATOR_limit_InBUS      (limit_bus),
        .CC_MULTISPEEDCOMPARATOR_limitSel_InBUS   (sel),
        .CC_MULTISPEEDCOMPARATOR_loadSignal_InLow (load_n),
        .CC_MULTISPEEDCOMPARATOR_clear_InHigh     (clear),
        .CC_MULTISPEEDCOMPARATOR_signal_OutLow    (sig),
        .CC_MULTISPEEDCOMPARATOR_any_OutLow       (any_n),
        .CC_MULTISPEEDCOMPARATOR_sticky_OutHigh   (sticky)
    );

    cc_multispeedcomparator #(
        .DATAWIDTH (DW), .CHANNELS (3), .PERSIST (PERS), .HYST (HY)
    ) dut3 (
        .CC_MULTISPEEDCOMPARATOR_CLOCK_50         (clk),
        .CC_MULTISPEEDCOMPARATOR_RESET_InLow      (rst_n),
        .CC_MULTISPEEDCOMPARATOR_data_InBUS       (data_bus[3*DW-1:0]),
        .CC_MULTISPEEDCOMPARATOR_dataValid_InHigh (valid),
        .CC_MULTISPEEDCOMPARATOR_limit_InBUS      (limit_bus),
        .CC_MULTISPEEDCOMPARATOR_limitSel_InBUS   (sel3),
        .CC_MULTISPEEDCOMPARATOR_loadSignal_InLow (load3_n),
        .CC_MULTISPEEDCOMPARATOR_clear_InHigh     (clear),
        .CC_MULTISPEEDCOMPARATOR_signal_OutLow    (sig3),
        .CC_MULTISPEEDCOMPARATOR_any_OutLow       (any3),
        .CC_MULTISPEEDCOMPARATOR_sticky_OutHigh   (sticky3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NCH*DW-1:0] pack4(input logic [7:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic modelReset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_limit[ch]  = 255;
            m_alarm[ch]  = 1'b0;
            m_run[ch]    = 0;
            m_sticky[ch] = 1'b0;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The model counts consecutive qualifying samples.
    //   - Not alarmed: PERSIST samples at or above the limit enter the alarm.
    //   - Alarmed: PERSIST samples with sample + HYST below the limit leave it.
    //   - Any non-qualifying sample restarts the run.
    //   - A write to a channel resets that channel and drops its sample.
    task automatic applyStimulus(input logic [NCH*DW-1:0] d, input logic v,
                                 input logic ld_n, input logic [1:0] s,
                                 input logic [7:0] lim, input logic clr);
        for (int ch = 0; ch < NCH; ch++) begin
            int  dv;
            bit  entered;
            dv      = int'(d[ch*DW +: DW]);
            entered = 1'b0;
            if (!ld_n && (int'(s) == ch)) begin
                m_limit[ch] = int'(lim);
                m_alarm[ch] = 1'b0;
                m_run[ch]   = 0;
            end else if (v) begin
                if (!m_alarm[ch]) begin
                    if (dv >= m_limit[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] == PERS) begin
                            m_alarm[ch] = 1'b1;
                            m_run[ch]   = 0;
                            entered     = 1'b1;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                end else begin
                    if (dv + HY < m_limit[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] == PERS) begin
                            m_alarm[ch] = 1'b0;
                            m_run[ch]   = 0;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                end
            end
            m_sticky[ch] = entered || (m_sticky[ch] && !clr);
        end
        data_bus  = d;
        valid     = v;
        load_n    = ld_n;
        sel       = s;
        limit_bus = lim;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [NCH-1:0] exp_sig;
        logic [NCH-1:0] exp_sticky;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_sig[ch]    = !m_alarm[ch];
            exp_sticky[ch] = m_sticky[ch];
        end
        checkValue({tag, "/signal"}, 32'(sig), 32'(exp_sig));
        checkValue({tag, "/any"}, 32'(any_n), 32'(&exp_sig));
        checkValue({tag, "/sticky"}, 32'(sticky), 32'(exp_sticky));
    endtask

    // Reset is asserted and released between clock edges.
    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int seq_arm [6];
        int seq_rel [5];
        logic [NCH*DW-1:0] d;
        int v;

        tests_run    = 0;
        tests_failed = 0;
        seq_arm      = '{100, 101, 99, 100, 100, 100};
        seq_rel      = '{97, 96, 95, 95, 95};
        rst_n     = 1'b0;
        data_bus  = '0;
        valid     = 1'b0;
        limit_bus = '0;
        sel       = '0;
        load_n    = 1'b1;
        clear     = 1'b0;
        sel3      = '0;
        load3_n   = 1'b1;
        modelReset();
        #12;
        rst_n = 1'b1;

        // 1. Reset state and the default limit of 255.
        checkValue("reset/signal", 32'(sig), 32'h0000000F);
        checkValue("reset/any", 32'(any_n), 32'h1);
        checkValue("reset/sticky", 32'(sticky), 32'h0);
        checkValue("reset/signal3", 32'(sig3), 32'h7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus({NCH{8'd254}}, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("idle254");
        end
        checkValue("idle254/signal", 32'(sig), 32'h0000000F);
        for (int i = 0; i < 3; i++) begin
            applyStimulus({NCH{8'd255}}, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("init255");
        end
        checkValue("init255/signal", 32'(sig), 32'h0);
        checkValue("init255/sticky", 32'(sticky), 32'hF);
        doReset();

        // 2. Persistence on channel 1 with limit 100.
        applyStimulus('0, 1'b0, 1'b0, 2'd1, 8'd100, 1'b0);
        checkOutput("load_ch1");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(pack4(8'd0, 8'(seq_arm[i]), 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("persist");
        end
        checkValue("persist/signal", 32'(sig), 32'b1101);
        checkValue("persist/any", 32'(any_n), 32'h0);
        checkValue("persist/sticky", 32'(sticky), 32'b0010);

        // 3. Hysteresis release, then clear of the sticky flag.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pack4(8'd0, 8'(seq_rel[i]), 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("hyst");
        end
        checkValue("hyst/signal", 32'(sig), 32'hF);
        checkValue("hyst/sticky", 32'(sticky), 32'b0010);
        applyStimulus('0, 1'b0, 1'b1, 2'd0, 8'd0, 1'b1);
        checkValue("clear/sticky", 32'(sticky), 32'h0);

        // 4a. A limit of zero alarms on any sample value.
        applyStimulus('0, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(pack4(8'd0, 8'd0, 8'($urandom_range(0, 255)), 8'd0),
                          1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("limit0");
        end
        checkValue("limit0/signal", 32'(sig), 32'b1011);

        // 4b. A limit at or below HYST never releases; a reload releases at once.
        applyStimulus('0, 1'b0, 1'b0, 2'd3, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(pack4(8'd0, 8'd0, 8'd0, 8'd3), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("limit3_arm");
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pack4(8'd0, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("limit3_hold");
        end
        checkValue("limit3_hold/signal3", 32'(sig[3]), 32'h0);
        applyStimulus(pack4(8'd0, 8'd0, 8'd0, 8'd0), 1'b1, 1'b0, 2'd3, 8'd50, 1'b0);
        checkValue("reload50/signal3", 32'(sig[3]), 32'h1);
        checkOutput("reload50");

        // 4c. A reload during arming restarts the count.
        applyStimulus('0, 1'b0, 1'b0, 2'd0, 8'd10, 1'b0);
        for (int i = 0; i < 2; i++)
            applyStimulus(pack4(8'd20, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        applyStimulus(pack4(8'd20, 8'd0, 8'd0, 8'd0), 1'b1, 1'b0, 2'd0, 8'd10, 1'b0);
        for (int i = 0; i < 2; i++)
            applyStimulus(pack4(8'd20, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("rearm/signal0_early", 32'(sig[0]), 32'h1);
        checkOutput("rearm_early");
        applyStimulus(pack4(8'd20, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("rearm/signal0", 32'(sig[0]), 32'h0);
        checkOutput("rearm");

        // 5a. A load and a sample on the same edge: the load wins.
        applyStimulus(pack4(8'd200, 8'd0, 8'd0, 8'd0), 1'b1, 1'b0, 2'd0, 8'd10, 1'b0);
        checkValue("loadvalid/signal0", 32'(sig[0]), 32'h1);
        for (int i = 0; i < 2; i++)
            applyStimulus(pack4(8'd200, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("loadvalid/signal0_2", 32'(sig[0]), 32'h1);
        applyStimulus(pack4(8'd200, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("loadvalid/signal0_3", 32'(sig[0]), 32'h0);
        checkOutput("loadvalid");

        // 5b. A sticky set and a clear on the same edge: the set wins.
        applyStimulus('0, 1'b0, 1'b1, 2'd0, 8'd0, 1'b1);
        for (int i = 0; i < 2; i++)
            applyStimulus(pack4(8'd200, 8'd200, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        applyStimulus(pack4(8'd200, 8'd200, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b1);
        checkValue("setclear/sticky1", 32'(sticky[1]), 32'h1);
        checkOutput("setclear");

        // 5c. Three-channel instance: a select of 3 writes nothing.
        doReset();
        sel3    = 2'd3;
        load3_n = 1'b0;
        applyStimulus('0, 1'b0, 1'b1, 2'd0, 8'd0, 1'b0);
        load3_n = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus({NCH{8'd200}}, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("sel3/signal3", 32'(sig3), 32'h7);
        checkValue("sel3/any3", 32'(any3), 32'h1);
        for (int i = 0; i < 3; i++)
            applyStimulus({NCH{8'd255}}, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("sel3/signal3_255", 32'(sig3), 32'h0);
        checkValue("sel3/any3_255", 32'(any3), 32'h0);
        checkValue("sel3/sticky3", 32'(sticky3), 32'h7);
        checkOutput("sel3_main");

        // 6. Asynchronous reset while channel 1 is alarmed.
        doReset();
        applyStimulus('0, 1'b0, 1'b0, 2'd1, 8'd100, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(pack4(8'd0, 8'd150, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
        checkValue("async_pre/signal", 32'(sig), 32'b1101);
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("async/signal", 32'(sig), 32'hF);
        checkValue("async/any", 32'(any_n), 32'h1);
        checkValue("async/sticky", 32'(sticky), 32'h0);
        #1;
        rst_n = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(pack4(8'd0, 8'd254, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("async_lim254");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(pack4(8'd0, 8'd255, 8'd0, 8'd0), 1'b1, 1'b1, 2'd0, 8'd0, 1'b0);
            checkOutput("async_lim255");
        end
        checkValue("async_lim255/signal", 32'(sig), 32'b1101);

        // 7. Random traffic. Samples cluster around each channel's limit.
        doReset();
        for (int n = 0; n < 500; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 7) == 0)
                    v = int'($urandom_range(0, 255));
                else
                    v = m_limit[ch] + int'($urandom_range(0, 16)) - 8;
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
                d[ch*DW +: DW] = 8'(v);
            end
            applyStimulus(d, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) != 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6))
                                                      : 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 19) == 0));
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
